// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch path: fetch FSM states,
// instruction field positions and default widths.
package instruction_fetch_unit_pkg;

  localparam int ADDR_W_DEF  = 5;
  localparam int INSTR_W_DEF = 16;

  // Opcode field position, shared with instruction_register and arithmetic_logic_unit.
  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Prefetch FIFO with a registered head word; flush takes priority over
// push and pop issued in the same cycle.
module fetch_queue #(
  parameter  int DEPTH   = 2,
  parameter  int INSTR_W = 16,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [INSTR_W-1:0] wdata,
  output logic [INSTR_W-1:0] rdata,
  output logic [CNT_W-1:0]   count,
  output logic               empty
);

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [INSTR_W-1:0] rdata_q, rdata_d;
  logic               push_eff;
  logic               pop_eff;

  assign push_eff = push & ~flush;
  assign pop_eff  = pop & ~flush & (count_q != '0);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    rdata_d = rdata_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_eff) wptr_d = wptr_q + PTR_W'(1);
      if (pop_eff)  rptr_d = rptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_eff) - CNT_W'(pop_eff);
      // Head register tracks the oldest entry; it keeps its last value when empty.
      if ((count_q - CNT_W'(pop_eff)) == '0) begin
        if (push_eff) rdata_d = wdata;
      end else if (pop_eff) begin
        rdata_d = mem_q[rptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      rdata_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_eff) mem_q[wptr_q] <= wdata;
  end

  assign rdata = rdata_q;
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: requests words from instruction memory at fetch_pc,
// buffers them in a prefetch queue and offers the head to the instruction register.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int DEPTH   = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ld_pc,
  input  logic [ADDR_W-1:0]           pc_target,
  output logic                        imem_req,
  output logic [ADDR_W-1:0]           imem_addr,
  input  logic                        imem_ack,
  input  logic [INSTR_W-1:0]          imem_rdata,
  output logic                        instr_valid,
  input  logic                        instr_ready,
  output logic [INSTR_W-1:0]          instr_word,
  output logic [OPCODE_MSB:0]         instr_opcode,
  output logic [INSTR_W-OPCODE_MSB-2:0] instr_addr,
  output logic [ADDR_W-1:0]           fetch_pc,
  output fetch_state_e                dbg_state
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_e        state_q, state_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic                imem_req_q, imem_req_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic                q_push;
  logic                q_pop;
  logic [CNT_W-1:0]    q_count;
  logic                q_empty;

  // Handshake: the head word transfers on any cycle where instr_valid and
  // instr_ready are both high; instr_word is stable while valid and not taken.
  assign q_pop = instr_valid & instr_ready;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    imem_req_d  = imem_req_q;
    imem_addr_d = imem_addr_q;
    q_push      = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld_pc) begin
          fetch_pc_d = pc_target;
        end else if (q_count < CNT_W'(DEPTH)) begin
          imem_req_d  = 1'b1;
          imem_addr_d = fetch_pc_q;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (ld_pc) begin
          fetch_pc_d = pc_target;
          if (imem_ack) begin
            imem_req_d = 1'b0;
            state_d    = IDLE;
          end else begin
            state_d = DROP;
          end
        end else if (imem_ack) begin
          q_push     = 1'b1;
          fetch_pc_d = fetch_pc_q + ADDR_W'(1);
          imem_req_d = 1'b0;
          state_d    = IDLE;
        end
      end
      DROP: begin
        // The stale response must still drain before a new request can go out.
        if (ld_pc) fetch_pc_d = pc_target;
        if (imem_ack) begin
          imem_req_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        imem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      fetch_pc_q  <= '0;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
    end
  end

  fetch_queue #(
    .DEPTH   (DEPTH),
    .INSTR_W (INSTR_W)
  ) u_fetch_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .flush (ld_pc),
    .wdata (imem_rdata),
    .rdata (instr_word),
    .count (q_count),
    .empty (q_empty)
  );

  assign instr_valid  = ~q_empty;
  assign instr_opcode = instr_word[OPCODE_MSB:OPCODE_LSB];
  assign instr_addr   = instr_word[INSTR_W-1:OPCODE_MSB+1];
  assign imem_req     = imem_req_q;
  assign imem_addr    = imem_addr_q;
  assign fetch_pc     = fetch_pc_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit against a transaction-level model:
// expected word stream, next fetch address and a pending-discard flag.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst;
  logic        ld_pc;
  logic [4:0]  pc_target;
  logic        imem_req;
  logic [4:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_word;
  logic [2:0]  instr_opcode;
  logic [12:0] instr_addr;
  logic [4:0]  fetch_pc;
  logic [1:0]  dbg_state;

  instruction_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .ld_pc        (ld_pc),
    .pc_target    (pc_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_word   (instr_word),
    .instr_opcode (instr_opcode),
    .instr_addr   (instr_addr),
    .fetch_pc     (fetch_pc),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instruction memory and reference model state
  logic [15:0] mem [32];
  logic [15:0] exp_q [$];
  logic [15:0] last_word;
  logic [4:0]  model_pc;
  bit          discard;

  // stimulus knobs
  int p_ack, p_ready, p_ld, p_spur, ack_delay, req_cycles;
  bit dead_next, saw_req, saw_dead;
  bit prev_req, prev_ack;
  logic [4:0] prev_addr;

  int n_checks;
  int n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_word  = 16'h0000;
    model_pc   = 5'd0;
    discard    = 1'b0;
    req_cycles = 0;
    prev_req   = 1'b0;
    prev_ack   = 1'b0;
    prev_addr  = 5'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b1;
    ld_pc       = 1'b0;
    instr_ready = 1'b0;
    imem_ack    = 1'b1;
    imem_rdata  = 16'hBEEF;
    repeat (2) @(negedge clk);
    check("rst_req",      imem_req,     1'b0);
    check("rst_addr",     imem_addr,    5'd0);
    check("rst_valid",    instr_valid,  1'b0);
    check("rst_word",     instr_word,   16'h0000);
    check("rst_fetch_pc", fetch_pc,     5'd0);
    check("rst_opcode",   instr_opcode, 3'd0);
    // A late ack arriving right after release must be ignored.
    rst      = 1'b0;
    imem_ack = 1'b1;
    model_reset();
  endtask

  // One clock: check outputs against the model, drive inputs, advance the model.
  task automatic step(input int ld_mode, input logic [4:0] tgt);
    logic [15:0] exp_word;
    @(negedge clk);
    exp_word = (exp_q.size() != 0) ? exp_q[0] : last_word;
    check("valid",      instr_valid,  exp_q.size() != 0);
    check("word",       instr_word,   exp_word);
    check("opcode",     instr_opcode, exp_word[2:0]);
    check("addr_field", instr_addr,   exp_word[15:3]);
    check("fetch_pc",   fetch_pc,     model_pc);
    if (imem_req && prev_req && !prev_ack) check("addr_hold", imem_addr, prev_addr);
    if (instr_valid && instr_word == 16'hDEAD) saw_dead = 1'b1;

    ld_pc       = (ld_mode == 1) || (ld_mode < 0 && $urandom_range(0, 99) < p_ld);
    pc_target   = (ld_mode == 1) ? tgt : 5'($urandom_range(0, 31));
    instr_ready = ($urandom_range(0, 99) < p_ready);
    saw_req     = imem_req;
    if (imem_req) begin
      imem_ack   = (ack_delay >= 0) ? (req_cycles >= ack_delay) : ($urandom_range(0, 99) < p_ack);
      imem_rdata = dead_next ? 16'hDEAD : mem[imem_addr];
      if (imem_ack && !discard && !ld_pc) check("req_addr", imem_addr, model_pc);
      if (imem_ack) begin
        dead_next  = 1'b0;
        req_cycles = 0;
      end else begin
        req_cycles++;
      end
    end else begin
      imem_ack   = ($urandom_range(0, 99) < p_spur);
      imem_rdata = 16'hBEEF;
      req_cycles = 0;
    end

    if (ld_pc) begin
      if (imem_req) discard = !imem_ack;
      exp_q.delete();
      model_pc = pc_target;
    end else begin
      if (exp_q.size() != 0 && instr_ready) void'(exp_q.pop_front());
      if (imem_req && imem_ack) begin
        if (discard) begin
          discard = 1'b0;
        end else begin
          exp_q.push_back(mem[model_pc]);
          model_pc = model_pc + 5'd1;
        end
      end
    end
    if (exp_q.size() != 0) last_word = exp_q[0];
    if (exp_q.size() > 2) check("q_overflow", exp_q.size(), 2);
    prev_req  = imem_req;
    prev_ack  = imem_ack;
    prev_addr = imem_addr;
  endtask

  task automatic wait_req();
    saw_req = 1'b0;
    for (int i = 0; i < 20 && !saw_req; i++) step(0, 5'd0);
    if (!saw_req) check("req_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    ld_pc     = 1'b0;
    pc_target = 5'd0;
    imem_ack  = 1'b0;
    imem_rdata = 16'h0000;
    instr_ready = 1'b0;
    dead_next = 1'b0;
    saw_dead  = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 16'($urandom) & 16'h7FFF;
    mem[0] = 16'h0039;
    mem[1] = 16'h0052;
    model_reset();

    // Ack tied high, no consumer: two fetches then stall with the queue full.
    p_ack = 100; p_ready = 0; p_ld = 0; p_spur = 0; ack_delay = 0;
    do_reset();
    step(0, 5'd0);
    check("lat_req",  imem_req,  1'b1);
    check("lat_addr", imem_addr, 5'd0);
    repeat (7) step(0, 5'd0);
    check("full_req",    imem_req,     1'b0);
    check("full_valid",  instr_valid,  1'b1);
    check("full_word",   instr_word,   16'h0039);
    check("full_opcode", instr_opcode, 3'b001);
    check("full_afield", instr_addr,   13'h7);

    // Steady consumer: in-order stream through the 31 -> 0 wrap.
    p_ready = 100;
    repeat (90) step(0, 5'd0);

    // Slow memory: each ack arrives on the fourth request cycle.
    ack_delay = 3;
    repeat (40) step(0, 5'd0);

    // Redirect to 20 while waiting; the stale response carries 0xDEAD.
    wait_req();
    dead_next = 1'b1;
    step(1, 5'd20);
    step(0, 5'd0);
    check("redir_valid", instr_valid, 1'b0);
    check("redir_pc",    fetch_pc,    5'd20);
    repeat (30) step(0, 5'd0);
    check("no_dead", saw_dead, 1'b0);

    // Random mix of acks, backpressure, redirects and stray acks.
    ack_delay = -1; p_ack = 50; p_ready = 50; p_ld = 8; p_spur = 20;
    repeat (3000) step(-1, 5'd0);
    check("no_dead_rand", saw_dead, 1'b0);

    // Reset while a request is outstanding; fetch must restart at 0.
    ack_delay = 5; p_ld = 0; p_spur = 0; p_ready = 0;
    wait_req();
    step(0, 5'd0);
    do_reset();
    ack_delay = 0;
    step(0, 5'd0);
    check("restart_req",  imem_req,  1'b1);
    check("restart_addr", imem_addr, 5'd0);
    p_ready = 70;
    repeat (40) step(0, 5'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Upstream neighbour of the instruction register. It fetches 16-bit instruction words from instruction memory at the fetch PC and buffers them in a small prefetch queue.
- It presents the oldest word, already split into opcode and address fields, to the instruction register through a valid/ready handshake.
- A PC load from the control sequencer redirects fetch, flushes the queue, and discards any in-flight response.

Parameters:
- ADDR_W, 5: fetch PC / instruction memory address width.
- INSTR_W, 16: instruction word width. Opcode is bits [2:0]; address field is bits [INSTR_W-1:3].
- DEPTH, 2: prefetch queue entries (power of 2, ≥2).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- ld_pc  in  1  redirect request from the control sequencer.
- pc_target  in  ADDR_W  redirect address, sampled when ld_pc=1.
- imem_req  out  1  memory read request (registered).
- imem_addr  out  ADDR_W  read address; stable while imem_req=1.
- imem_ack  in  1  read data valid this cycle; only meaningful while imem_req=1.
- imem_rdata  in  INSTR_W  read data, qualified by imem_ack.
- instr_valid  out  1  queue head holds a valid instruction.
- instr_ready  in  1  instruction register accepts the head (its ld_IR).
- instr_word  out  INSTR_W  queue head word.
- instr_opcode  out  3  instr_word[2:0].
- instr_addr  out  INSTR_W-3  instr_word[INSTR_W-1:3].
- fetch_pc  out  ADDR_W  address of the next word to request.

Behaviour:
- Reset (rst=1 at a clock edge; overrides everything, including mid-request):
  - fetch_pc=0, state=IDLE, queue count=0.
  - imem_req=0, imem_addr=0, instr_valid=0, instr_word=0.
  - Any outstanding memory response is abandoned; an ack seen while imem_req=0 is ignored.
- FSM states: IDLE, WAIT, DROP.
- IDLE:
  - If ld_pc=0 and count<DEPTH: next cycle imem_req=1, imem_addr=fetch_pc, go to WAIT.
  - Otherwise stay in IDLE with imem_req=0.
  - Throughput limit: one request per two cycles minimum (issue, then ack).
- WAIT (imem_req=1, address held):
  - imem_ack=1 and ld_pc=0: push imem_rdata to queue tail; fetch_pc+=1 (wraps 2^ADDR_W-1 → 0); imem_req=0; go to IDLE.
  - imem_ack=0 and ld_pc=0: hold; no timeout.
  - ld_pc=1 and imem_ack=1: discard the data; fetch_pc=pc_target; go to IDLE.
  - ld_pc=1 and imem_ack=0: fetch_pc=pc_target; go to DROP, keeping imem_req=1 and imem_addr at the old address.
- DROP:
  - Wait for imem_ack. Discard its data, deassert imem_req, go to IDLE.
  - ld_pc=1 in DROP: update fetch_pc to the new pc_target and stay in DROP.
- Queue:
  - FIFO of DEPTH entries.
  - Push only on a non-discarded ack. A request is issued only when count<DEPTH, so overflow is impossible.
  - Pop when instr_valid && instr_ready.
  - Push and pop in the same cycle: count unchanged.
  - Empty: instr_valid=0; instr_word holds its last value (0 after reset).
  - Data written by a push is visible on instr_word/instr_valid the cycle after the ack.
- Redirect:
  - ld_pc=1 sets count=0 at that edge, so instr_valid=0 on the next cycle.
  - A pop and a push in the same cycle as ld_pc are both cancelled; flush wins.
  - New fetch from pc_target is issued the cycle after reaching IDLE.
- Latency:
  - Ack in the first request cycle: instr_valid rises 1 cycle after that ack.
  - From reset release: req at cycle 1, ack at cycle 1, valid at cycle 2.
- Outputs:
  - imem_req, imem_addr, instr_valid, instr_word, fetch_pc are registered.
  - instr_opcode and instr_addr are wires sliced from instr_word.

Decomposition:
- Shared package:
  - FSM state enum {IDLE, WAIT, DROP}.
  - Opcode field LSB/MSB constants (shared with instruction_register and arithmetic_logic_unit).
  - Default ADDR_W / INSTR_W constants.
- Sub-module fetch_queue:
  - Parameters DEPTH, INSTR_W.
  - Ports: push, pop, flush, wdata, rdata, count, empty.
  - Registered pointers with wrap.
- FSM and PC logic stay in the top module.

Test Plan:
- Reset, imem_ack tied 1, instr_ready=0, mem[0]=16'h0039, mem[1]=16'h0052:
  - Requests to addr 0 then 2 cycles later addr 1; then stops (queue full, count=2).
  - instr_word=16'h0039, instr_opcode=3'b001, instr_addr=13'h7.
- Same setup, then instr_ready=1 steadily:
  - Words pop in order 0x0039, 0x0052, mem[2], ...
  - No duplicates or drops; fetch_pc wraps 31 → 0 and mem[0] is refetched.
- imem_ack delayed 3 cycles:
  - imem_req and imem_addr=4 held constant throughout.
  - Single push on the ack cycle.
- ld_pc=1, pc_target=5'd20 while in WAIT with no ack; ack 2 cycles later with data 16'hDEAD:
  - DEAD never appears on instr_word.
  - instr_valid=0 from the next cycle.
  - Next request addresses 20.
- ld_pc in the same cycle as a push and a pop:
  - Queue empty next cycle; pushed word discarded; fetch_pc=pc_target.
- rst asserted in WAIT with an ack arriving later:
  - All outputs return to reset values.
  - The late ack is ignored; fetch restarts at addr 0.
